// File: rtl/mem_access.sv
// Pipeline MEM stage: data-memory load/store over a req/ack handshake, branch resolution, MEM/WB register.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [31:0] PCBranch_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  MemBranch_pype2,
    input  logic [31:0] Instraction_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        branch_PC_contral,
    output logic [31:0] branch_PC,
    output logic [31:0] ReadData_pype3,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic        RegWrite_pype3,
    output logic [1:0]  MemtoReg_pype3,
    output logic [31:0] Instraction_pype3
);

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic [31:0] readData_q, aluCo_q, pcp4_q, instr_q;
    logic [4:0]  wReg_q;
    logic        regWrite_q;
    logic [1:0]  memtoReg_q;

    logic [1:0]  lane;
    logic [1:0]  accSize;
    logic        isLoad;
    logic        isStore;
    logic        memAccess;
    logic        misaligned;
    logic        accessEff;
    logic        timeout;
    logic        completing;
    logic [31:0] shifted;
    logic [31:0] loadData;
    logic        branchCond;

    assign lane      = ALU_co_pype[1:0];
    assign accSize   = Instraction_pype2[13:12];
    assign isLoad    = (MemRW_pype2 == 2'b01);
    assign isStore   = (MemRW_pype2 == 2'b10);
    assign memAccess = isLoad | isStore;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = memAccess &
                        (((accSize == 2'b01) & lane[0]) | (accSize[1] & (lane != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // A trapped misaligned access never reaches memory and never stalls.
    assign accessEff  = memAccess & ~misaligned;
    assign timeout    = accessEff & (state_q == S_WAIT) & ~dmem_ack & (cnt_q == TimeoutCnt);
    assign completing = accessEff & (dmem_ack | timeout);
    assign mem_stall  = accessEff & ~completing;
    assign mem_fault  = timeout | misaligned;

    assign dmem_req  = accessEff;
    assign dmem_we   = accessEff & isStore;
    assign dmem_addr = {ALU_co_pype[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = read_data2_pype2;
        case (accSize)
            2'b00: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{read_data2_pype2[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << lane;
                dmem_wdata = {2{read_data2_pype2[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = read_data2_pype2;
            end
        endcase
    end

    // Bit 14 of the instruction selects zero-extension; word loads take the raw word.
    always_comb begin
        shifted  = dmem_rdata >> {lane, 3'b000};
        loadData = dmem_rdata;
        case (accSize)
            2'b00:   loadData = {{24{~Instraction_pype2[14] & shifted[7]}}, shifted[7:0]};
            2'b01:   loadData = {{16{~Instraction_pype2[14] & shifted[15]}}, shifted[15:0]};
            default: loadData = dmem_rdata;
        endcase
    end

    always_comb begin
        branchCond = 1'b0;
        case (MemBranch_pype2)
            3'b001:  branchCond = (ALU_co_pype == 32'd0);
            3'b010:  branchCond = (ALU_co_pype != 32'd0);
            3'b011:  branchCond = (ALU_co_pype == 32'd1);
            3'b101:  branchCond = (ALU_co_pype == 32'd0);
            3'b100:  branchCond = 1'b1;
            default: branchCond = 1'b0;
        endcase
    end

    assign branch_PC_contral = branchCond & ~mem_stall;
    assign branch_PC         = branch_PC_contral ? PCBranch_pype2 : RESET_PC;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accessEff && !dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd1;
                end
            end
            S_WAIT: begin
                if (!accessEff || completing) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // While stalled the MEM/WB register takes a bubble so WB never sees a half-done access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            readData_q <= 32'd0;
            aluCo_q    <= 32'd0;
            pcp4_q     <= 32'd0;
            instr_q    <= 32'd0;
            wReg_q     <= 5'd0;
            regWrite_q <= 1'b0;
            memtoReg_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (mem_stall) begin
                readData_q <= 32'd0;
                aluCo_q    <= 32'd0;
                pcp4_q     <= 32'd0;
                instr_q    <= 32'd0;
                wReg_q     <= 5'd0;
                regWrite_q <= 1'b0;
                memtoReg_q <= 2'b00;
            end else begin
                readData_q <= (isLoad && accessEff && !timeout) ? loadData : 32'd0;
                aluCo_q    <= ALU_co_pype;
                pcp4_q     <= PCp4_pype2;
                instr_q    <= Instraction_pype2;
                wReg_q     <= WReg_pype2;
                regWrite_q <= RegWrite_pype2 & ~misaligned;
                memtoReg_q <= MemtoReg_pype2;
            end
        end
    end

    assign ReadData_pype3    = readData_q;
    assign ALU_co_pype3      = aluCo_q;
    assign PCp4_pype3        = pcp4_q;
    assign Instraction_pype3 = instr_q;
    assign WReg_pype3        = wReg_q;
    assign RegWrite_pype3    = regWrite_q;
    assign MemtoReg_pype3    = memtoReg_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT_CYCLES = 4, RESET_PC = 0x100).
// Misaligned-access expectations follow MEM_MISALIGN_TRAP_EN when it is defined.
module tb_mem_access;

    localparam logic [31:0] ResetPc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_co_pype, read_data2_pype2, PCBranch_pype2, PCp4_pype2;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [31:0] Instraction_pype2;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, mem_fault, branch_PC_contral;
    logic [31:0] branch_PC, ReadData_pype3, ALU_co_pype3, PCp4_pype3, Instraction_pype3;
    logic [4:0]  WReg_pype3;
    logic        RegWrite_pype3;
    logic [1:0]  MemtoReg_pype3;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(4), .RESET_PC(ResetPc)) dut (
        .clk(clk), .rst(rst),
        .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
        .PCBranch_pype2(PCBranch_pype2), .PCp4_pype2(PCp4_pype2),
        .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
        .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
        .MemBranch_pype2(MemBranch_pype2), .Instraction_pype2(Instraction_pype2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
        .branch_PC_contral(branch_PC_contral), .branch_PC(branch_PC),
        .ReadData_pype3(ReadData_pype3), .ALU_co_pype3(ALU_co_pype3),
        .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
        .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
        .Instraction_pype3(Instraction_pype3)
    );

    // Drives one EX/MEM vector; funct3 lands in instruction bits [14:12].
    task automatic applyStimulus(input logic [1:0] memRw, input logic [2:0] funct3,
                                 input logic [31:0] alu, input logic [31:0] storeData,
                                 input logic [31:0] rdata, input logic ack,
                                 input logic [2:0] memBranch, input logic regWrite,
                                 input logic [4:0] wReg);
        MemRW_pype2       = memRw;
        Instraction_pype2 = {17'h0, funct3, 5'h0, 7'h03};
        ALU_co_pype       = alu;
        read_data2_pype2  = storeData;
        dmem_rdata        = rdata;
        dmem_ack          = ack;
        MemBranch_pype2   = memBranch;
        RegWrite_pype2    = regWrite;
        WReg_pype2        = wReg;
        PCBranch_pype2    = 32'h0000_0040;
        PCp4_pype2        = 32'h0000_0044;
        MemtoReg_pype2    = 2'b01;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(2'b00, 3'b000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 1'b0, 3'b000, 1'b1, 5'd7);
        tick();
        tick();
        checkOutput("rst_readdata", ReadData_pype3, 32'h0);
        checkOutput("rst_alu", ALU_co_pype3, 32'h0);
        checkOutput("rst_regwrite", {31'h0, RegWrite_pype3}, 32'h0);
        checkOutput("rst_wreg", {27'h0, WReg_pype3}, 32'h0);
        checkOutput("rst_instr", Instraction_pype3, 32'h0);
        checkOutput("rst_req", {31'h0, dmem_req}, 32'h0);

        rst = 1'b1;
        // Store byte at lane 3, acked in the request cycle.
        applyStimulus(2'b10, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1'b1, 3'b000, 1'b0, 5'd0);
        checkOutput("sb_req", {31'h0, dmem_req}, 32'h1);
        checkOutput("sb_we", {31'h0, dmem_we}, 32'h1);
        checkOutput("sb_be", {28'h0, dmem_be}, 32'h8);
        checkOutput("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_addr", dmem_addr, 32'h0000_0100);
        checkOutput("sb_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        checkOutput("sb_alu3", ALU_co_pype3, 32'h0000_0103);
        checkOutput("sb_pcp4_3", PCp4_pype3, 32'h0000_0044);

        // Store half at lane 2 and store word.
        applyStimulus(2'b10, 3'b001, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0, 1'b1, 3'b000, 1'b0, 5'd0);
        checkOutput("sh_be", {28'h0, dmem_be}, 32'hC);
        checkOutput("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        tick();
        applyStimulus(2'b10, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 1'b1, 3'b000, 1'b0, 5'd0);
        checkOutput("sw_be", {28'h0, dmem_be}, 32'hF);
        checkOutput("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        tick();

        // Signed half load with the ack arriving on the fourth request cycle.
        applyStimulus(2'b01, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_1234, 1'b0, 3'b000, 1'b1, 5'd5);
        checkOutput("lh_we", {31'h0, dmem_we}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("lh_stall%0d", i), {31'h0, mem_stall}, 32'h1);
            tick();
            checkOutput($sformatf("lh_bubble%0d", i), {31'h0, RegWrite_pype3}, 32'h0);
        end
        dmem_ack = 1'b1;
        #1;
        checkOutput("lh_stall_done", {31'h0, mem_stall}, 32'h0);
        tick();
        checkOutput("lh_data", ReadData_pype3, 32'hFFFF_8001);
        checkOutput("lh_regwrite", {31'h0, RegWrite_pype3}, 32'h1);
        checkOutput("lh_wreg", {27'h0, WReg_pype3}, 32'h5);
        checkOutput("lh_memtoreg", {30'h0, MemtoReg_pype3}, 32'h1);

        // Byte loads at lane 1, unsigned then signed.
        applyStimulus(2'b01, 3'b100, 32'h0000_0301, 32'h0, 32'h1234_F678, 1'b1, 3'b000, 1'b1, 5'd6);
        tick();
        checkOutput("lbu_data", ReadData_pype3, 32'h0000_00F6);
        applyStimulus(2'b01, 3'b000, 32'h0000_0301, 32'h0, 32'h1234_F678, 1'b1, 3'b000, 1'b1, 5'd6);
        tick();
        checkOutput("lb_data", ReadData_pype3, 32'hFFFF_FFF6);

        // Branch resolution.
        applyStimulus(2'b00, 3'b001, 32'd5, 32'h0, 32'h0, 1'b0, 3'b010, 1'b0, 5'd0);
        checkOutput("bne_taken", {31'h0, branch_PC_contral}, 32'h1);
        checkOutput("bne_pc", branch_PC, 32'h0000_0040);
        applyStimulus(2'b00, 3'b001, 32'd0, 32'h0, 32'h0, 1'b0, 3'b010, 1'b0, 5'd0);
        checkOutput("bne_not", {31'h0, branch_PC_contral}, 32'h0);
        checkOutput("bne_not_pc", branch_PC, ResetPc);
        applyStimulus(2'b00, 3'b000, 32'd0, 32'h0, 32'h0, 1'b0, 3'b001, 1'b0, 5'd0);
        checkOutput("beq_taken", {31'h0, branch_PC_contral}, 32'h1);
        applyStimulus(2'b00, 3'b100, 32'd1, 32'h0, 32'h0, 1'b0, 3'b011, 1'b0, 5'd0);
        checkOutput("blt_taken", {31'h0, branch_PC_contral}, 32'h1);
        applyStimulus(2'b00, 3'b101, 32'd1, 32'h0, 32'h0, 1'b0, 3'b101, 1'b0, 5'd0);
        checkOutput("bge_not", {31'h0, branch_PC_contral}, 32'h0);
        applyStimulus(2'b00, 3'b000, 32'd7, 32'h0, 32'h0, 1'b0, 3'b100, 1'b1, 5'd1);
        checkOutput("jal_taken", {31'h0, branch_PC_contral}, 32'h1);
        tick();

        // Reserved MemRW behaves as a plain ALU instruction.
        applyStimulus(2'b11, 3'b010, 32'h0000_0400, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'b000, 1'b1, 5'd9);
        checkOutput("rsv_req", {31'h0, dmem_req}, 32'h0);
        checkOutput("rsv_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        checkOutput("rsv_readdata", ReadData_pype3, 32'h0);
        checkOutput("rsv_regwrite", {31'h0, RegWrite_pype3}, 32'h1);

        // Timeout: fault exactly on the fourth WAIT cycle.
        applyStimulus(2'b01, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1'b0, 3'b000, 1'b1, 5'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("to_nofault%0d", i), {31'h0, mem_fault}, 32'h0);
            tick();
        end
        checkOutput("to_fault", {31'h0, mem_fault}, 32'h1);
        checkOutput("to_stall_off", {31'h0, mem_stall}, 32'h0);
        tick();
        checkOutput("to_readdata", ReadData_pype3, 32'h0);
        checkOutput("to_idle_stall", {31'h0, mem_stall}, 32'h1);
        checkOutput("to_fault_gone", {31'h0, mem_fault}, 32'h0);
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        tick();

        // Reset while waiting, then a stray ack, then a fresh timeout count.
        applyStimulus(2'b01, 3'b010, 32'h0000_0500, 32'h0, 32'h1111_2222, 1'b0, 3'b000, 1'b1, 5'd4);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(2'b00, 3'b010, 32'h0000_0500, 32'h0, 32'h1111_2222, 1'b0, 3'b000, 1'b1, 5'd4);
        tick();
        checkOutput("rw_alu3", ALU_co_pype3, 32'h0);
        checkOutput("rw_regwrite", {31'h0, RegWrite_pype3}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("rw_req", {31'h0, dmem_req}, 32'h0);
        applyStimulus(2'b00, 3'b010, 32'h0, 32'h0, 32'h3333_4444, 1'b1, 3'b000, 1'b0, 5'd0);
        tick();
        checkOutput("rw_late_ack_rw", {31'h0, RegWrite_pype3}, 32'h0);
        checkOutput("rw_late_ack_rd", ReadData_pype3, 32'h0);
        applyStimulus(2'b01, 3'b010, 32'h0000_0600, 32'h0, 32'h0, 1'b0, 3'b000, 1'b1, 5'd2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rw_nofault%0d", i), {31'h0, mem_fault}, 32'h0);
            tick();
        end
        checkOutput("rw_fault", {31'h0, mem_fault}, 32'h1);
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        tick();

        // Misaligned word load.
        applyStimulus(2'b01, 3'b010, 32'h0000_0101, 32'h0, 32'h5566_7788, 1'b1, 3'b000, 1'b1, 5'd8);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis_req", {31'h0, dmem_req}, 32'h0);
        checkOutput("mis_fault", {31'h0, mem_fault}, 32'h1);
        checkOutput("mis_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        checkOutput("mis_regwrite", {31'h0, RegWrite_pype3}, 32'h0);
`else
        checkOutput("mis_req", {31'h0, dmem_req}, 32'h1);
        checkOutput("mis_be", {28'h0, dmem_be}, 32'hF);
        checkOutput("mis_fault", {31'h0, mem_fault}, 32'h0);
        tick();
        checkOutput("mis_data", ReadData_pype3, 32'h5566_7788);
        checkOutput("mis_regwrite", {31'h0, RegWrite_pype3}, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs: ALU result, store data, destination register, control lines and instruction word.
- Performs data-memory load/store over a req/ack handshake and resolves branches from the ALU result.
- Drives the MEM/WB pipeline register, raises a stall to freeze upstream stages, and reports the branch redirect to fetch.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waiting for dmem_ack before the access is aborted as a fault; range 1..65535.
- RESET_PC, 32'h0000_0000: value driven on branch_PC while no redirect is active.

Ports:
- clk  in  1  clock; every flop on rising edge
- rst  in  1  synchronous active-low reset
- ALU_co_pype  in  32  ALU result: address for load/store, compare result for branches
- read_data2_pype2  in  32  store data, unshifted
- PCBranch_pype2  in  32  branch/jump target
- PCp4_pype2  in  32  PC+4 (link value)
- WReg_pype2  in  5  destination register
- RegWrite_pype2  in  1  register write enable
- MemtoReg_pype2  in  2  writeback select, passed through
- MemRW_pype2  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- MemBranch_pype2  in  3  000 none, 001 beq, 010 bne, 011 blt/bltu, 101 bge/bgeu, 100 jal/jalr
- Instraction_pype2  in  32  instruction; bits [14:12] give access size/sign
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: ALU_co_pype with [1:0] forced to 0
- dmem_wdata  out  32  store data, lane-shifted
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  freeze IF/ID/EX (drives their keep)
- mem_fault  out  1  one-cycle pulse on timeout
- branch_PC_contral  out  1  redirect fetch this cycle
- branch_PC  out  32  redirect target
- ReadData_pype3, ALU_co_pype3, PCp4_pype3  out  32 each  MEM/WB data
- WReg_pype3  out  5; RegWrite_pype3  out  1; MemtoReg_pype3  out  2; Instraction_pype3  out  32

Behaviour:
- All MEM/WB outputs are registered. Synchronous reset (rst==0 at a rising edge) clears all of them to 0, returns the FSM to IDLE and clears the counter.
- Access condition: access = (MemRW_pype2 == 01 or 10).
- FSM state IDLE:
  - If access, assert dmem_req combinationally the same cycle.
  - If dmem_ack is also high, complete the access; otherwise go to WAIT with cnt = 1.
- FSM state WAIT:
  - Hold dmem_req and all request signals stable; increment cnt each cycle.
  - On ack, complete and return to IDLE.
  - When cnt reaches TIMEOUT_CYCLES without ack: pulse mem_fault, complete with ReadData = 0, go to IDLE.
- Stall: mem_stall = access & ~completing. It is combinational and never high when there is no access.
- MEM/WB update:
  - While mem_stall is high, the MEM/WB register loads a bubble: RegWrite = 0, other fields 0.
  - When not stalled, it loads the inputs. Minimum latency is 1 cycle (ack in the same cycle as the request).
- Store, size from Instraction_pype2[13:12] (00 byte, 01 half, 10 word); a = ALU_co_pype[1:0]:
  - dmem_be: byte 4'b0001 << a, half 4'b0011 << a, word 4'b1111.
  - dmem_wdata: store data replicated into lanes (byte x4, half x2, word).
- Load: the selected lane is right-shifted by 8*a. Instraction_pype2[14] = 0 sign-extends, 1 zero-extends. Word loads ignore bit 14.
- Branch taken (combinational, only when not stalled):
  - 001: ALU_co_pype == 0. 010: != 0. 011: == 1. 101: == 0. 100: always taken.
  - If taken: branch_PC_contral = 1 and branch_PC = PCBranch_pype2. Otherwise branch_PC = RESET_PC.
- Reset mid-WAIT: dmem_req drops the following cycle. A late ack after reset is ignored in IDLE when no access is present.
- MemRW = 11: no request, no stall, passes through as a non-memory instruction.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined, a misaligned access (half with a[0] = 1, or word with a != 0) is detected. That access:
  - suppresses dmem_req and does not stall;
  - pulses mem_fault for one cycle;
  - writes back with RegWrite_pype3 = 0.
- When not defined, misaligned addresses are not checked. The access proceeds using the be/shift rules above; the word with a != 0 uses be = 1111.

Test Plan:
- Store byte: ALU = 0x103, data = 0x000000AB, ack same cycle -> dmem_be = 1000, dmem_wdata = 0xABABABAB, dmem_we = 1, no mem_stall.
- Load half signed: ALU = 0x202, rdata = 0x8001_1234, funct3 = 001, ack after 3 cycles -> mem_stall high 3 cycles, then ReadData_pype3 = 0xFFFF8001. Bubbles (RegWrite_pype3 = 0) during the stall.
- Branch bne: MemBranch = 010, ALU = 5, PCBranch = 0x40 -> branch_PC_contral = 1, branch_PC = 0x40. With ALU = 0 -> branch_PC_contral = 0.
- Timeout: TIMEOUT_CYCLES = 4, load with ack never asserted -> mem_fault pulses on the 4th WAIT cycle, ReadData_pype3 = 0, FSM returns to IDLE.
- Reset in WAIT: rst low for one edge -> all pype3 outputs 0, dmem_req 0 next cycle. A subsequent ack with no access produces no writeback.
- With MEM_MISALIGN_TRAP_EN: word load at ALU = 0x101 -> no dmem_req, mem_fault = 1, RegWrite_pype3 = 0.
